// File: rtl/pcw_line_fetch.sv
// Per-line bitmap fetcher: roller-RAM lookup, byte prefetch FIFO and
// MSB-first pixel serialiser for the PCW video path.
module pcw_line_fetch #(
    parameter int BYTES_PER_LINE = 90,
    parameter int FIFO_DEPTH     = 4,
    parameter int BYTE_STRIDE    = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_stb,
    input  logic        i_linestart,
    input  logic        i_hblank,
    input  logic        i_vblank,
    input  logic [8:0]  i_y,
    input  logic [3:0]  i_roller_base,
    input  logic        i_screen_en,
    input  logic        i_inverse,
    output logic        o_mem_req,
    output logic [16:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [7:0]  i_mem_data,
    output logic        o_pixel,
    output logic        o_underrun
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int NW = $clog2(BYTES_PER_LINE + 1);
    localparam logic [CW-1:0] LP_DEPTH  = CW'(FIFO_DEPTH);
    localparam logic [NW-1:0] LP_BYTES  = NW'(BYTES_PER_LINE);
    localparam logic [16:0]   LP_STRIDE = 17'(BYTE_STRIDE);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ROLL_LO = 3'd1;
    localparam logic [2:0] S_ROLL_HI = 3'd2;
    localparam logic [2:0] S_FETCH   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_ABORT   = 3'd5;

    logic [2:0]    r_state;
    logic          r_req;
    logic [16:0]   r_addr;
    logic [7:0]    r_lo;
    logic [16:0]   r_next_addr;
    logic [NW-1:0] r_req_cnt;
    logic [NW-1:0] r_ack_cnt;
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_cnt;
    logic          r_pixel;
    logic          r_underrun;

    logic          w_ack;
    logic          w_ls;
    logic          w_active;
    logic          w_busy;
    logic          w_start;
    logic          w_abort;
    logic          w_flush;
    logic          w_push;
    logic [2:0]    w_bc;
    logic          w_load;
    logic          w_pop;
    logic [7:0]    w_byte;
    logic          w_bit;
    logic [CW-1:0] w_cnt_nxt;
    logic [16:0]   w_roll_lo;
    logic [15:0]   w_word;
    logic [16:0]   w_line_addr;
    logic          w_issue;
    logic          w_last;
    logic          w_unused;

    assign w_unused  = i_y[8];
    assign w_ack     = i_mem_ack & r_req;
    assign w_ls      = i_pix_stb & i_linestart;
    assign w_active  = i_pix_stb & ~i_hblank & ~i_vblank;
    assign w_busy    = (r_state == S_ROLL_LO) | (r_state == S_ROLL_HI)
                     | (r_state == S_FETCH);
    assign w_start   = w_ls & ~i_vblank
                     & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_abort   = w_ls & w_busy;
    assign w_flush   = w_start | w_abort;
    assign w_push    = w_ack & (r_state == S_FETCH) & ~w_abort;

    // Linestart restarts the byte phase even if that strobe is active.
    assign w_bc      = w_ls ? 3'd0 : r_bit_cnt;
    assign w_load    = w_active & (w_bc == 3'd0);
    assign w_pop     = w_load & (r_cnt != '0);
    assign w_byte    = (r_cnt != '0) ? r_fifo[r_rd] : 8'h00;
    assign w_bit     = w_load ? w_byte[7] : r_shift[7];
    assign w_cnt_nxt = w_flush ? '0
                     : r_cnt + CW'(w_push) - CW'(w_pop);

    assign w_roll_lo   = {4'b0, i_roller_base, i_y[7:0], 1'b0};
    assign w_word      = {i_mem_data, r_lo};
    assign w_line_addr = {w_word[15:3], 1'b0, w_word[2:0]};
    assign w_last      = (r_ack_cnt == LP_BYTES - 1'b1);

    // The in-flight byte already has a slot: w_cnt_nxt counts it as pushed on its ack.
    assign w_issue = (r_state == S_FETCH) & ~w_abort & (~r_req | w_ack)
                   & (r_req_cnt < LP_BYTES) & (w_cnt_nxt < LP_DEPTH);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_req       <= 1'b0;
            r_addr      <= '0;
            r_lo        <= '0;
            r_next_addr <= '0;
            r_req_cnt   <= '0;
            r_ack_cnt   <= '0;
        end else begin
            if (w_ack)
                r_req <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_state <= S_ROLL_LO;
                        r_req   <= 1'b1;
                        r_addr  <= w_roll_lo;
                    end else if (w_ls) begin
                        r_state <= S_IDLE;
                    end
                end
                S_ROLL_LO, S_ROLL_HI, S_FETCH: begin
                    if (w_abort) begin
                        if (r_req & ~w_ack) begin
                            r_state <= S_ABORT;
                        end else if (i_vblank) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_ROLL_LO;
                            r_req   <= 1'b1;
                            r_addr  <= w_roll_lo;
                        end
                    end else if (r_state == S_ROLL_LO) begin
                        if (w_ack) begin
                            r_lo    <= i_mem_data;
                            r_state <= S_ROLL_HI;
                            r_req   <= 1'b1;
                            r_addr  <= w_roll_lo | 17'd1;
                        end
                    end else if (r_state == S_ROLL_HI) begin
                        if (w_ack) begin
                            r_next_addr <= w_line_addr;
                            r_req_cnt   <= '0;
                            r_ack_cnt   <= '0;
                            r_state     <= S_FETCH;
                        end
                    end else begin
                        if (w_ack) begin
                            r_ack_cnt <= r_ack_cnt + 1'b1;
                            if (w_last)
                                r_state <= S_DONE;
                        end
                        if (w_issue) begin
                            r_req       <= 1'b1;
                            r_addr      <= r_next_addr;
                            r_next_addr <= r_next_addr + LP_STRIDE;
                            r_req_cnt   <= r_req_cnt + 1'b1;
                        end
                    end
                end
                S_ABORT: begin
                    if (w_ack) begin
                        if (i_vblank) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_ROLL_LO;
                            r_req   <= 1'b1;
                            r_addr  <= w_roll_lo;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_fifo[r_wr] <= i_mem_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (w_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push)
                r_wr <= r_wr + 1'b1;
            if (w_pop)
                r_rd <= r_rd + 1'b1;
            r_cnt <= w_cnt_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_pixel    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_active) begin
                r_bit_cnt <= w_bc + 3'd1;
                r_shift   <= w_load ? {w_byte[6:0], 1'b0}
                                    : {r_shift[6:0], 1'b0};
                if (w_load & (r_cnt == '0))
                    r_underrun <= 1'b1;
            end else if (w_ls) begin
                r_bit_cnt <= 3'd0;
            end
            if (i_pix_stb)
                r_pixel <= w_active & i_screen_en & (w_bit ^ i_inverse);
        end
    end

    assign o_mem_req  = r_req;
    assign o_mem_addr = r_addr;
    assign o_pixel    = r_pixel;
    assign o_underrun = r_underrun;
endmodule
